sel_mul_add_inverter: RTL and testbench
=======================================

Name: sel_mul_add_inverter

Overview:
- Sequential inverse of the select-multiply-add datapath `res = (sel ? a*b : c*d) + e` (mod 2^BW).
- Given `res`, `e`, both candidate multiplicands and `sel`, it recovers the other factor: quotient `q = ((res - e) mod 2^BW) / divisor`, plus remainder `r`.
- Multi-cycle restoring divider, one bit per clock, with valid/ready handshakes on both sides.
- Sits downstream of the multiply-add path, for consistency checking and operand recovery.

Parameters:
- BW, 8, operand/result width; BW >= 2.

Ports:
- clk  input  1  clock; all flops rise-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- res  input  BW  multiply-add result to invert.
- e  input  BW  addend to remove.
- b  input  BW  divisor when sel=1.
- d  input  BW  divisor when sel=0.
- sel  input  1  divisor select.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- q  output  BW  quotient.
- r  output  BW  remainder.
- div_zero  output  1  selected divisor was zero.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE.
  - in_ready=1, out_valid=0, q=0, r=0, div_zero=0.
  - Counter=0, internal registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge ("accept edge"):
    - Latch diff = res - e, truncated to BW bits (wrap-around is legal, e.g. res=3, e=10 gives 249).
    - Latch divisor = sel ? b : d.
    - Latch div_zero = (divisor==0).
    - Clear partial remainder; load counter = BW-1; go to CALC.
  - Inputs are ignored in every other state.
- CALC:
  - in_ready=0.
  - Each edge performs one restoring step, MSB of diff first:
    - pr' = {pr[BW-1:0], diff bit}, width BW+1.
    - If pr' >= divisor: pr = pr' - divisor and quotient bit = 1.
    - Otherwise: pr = pr' and quotient bit = 0.
  - The counter decrements; after the step with counter==0, register q/r, set out_valid=1, go to DONE.
  - Latency: out_valid is high in the cycle after the BW-th edge following the accept edge, i.e. BW cycles from accept.
- DONE:
  - out_valid=1; q, r and div_zero are held stable while out_ready=0 (no limit on stall length).
  - On out_valid&&out_ready at an edge: out_valid=0, go to IDLE.
  - in_ready is 0 in DONE, so there is no same-cycle accept; the minimum issue interval is BW+2 cycles.
- Divide by zero needs no special datapath: the restoring algorithm naturally yields q = all ones and r = diff; div_zero=1 flags it.
- q/r are updated only on the transition into DONE. Between transactions they retain their last values.
- Reset mid-operation: abandon the transaction immediately and restore all reset values; no output pulse.
- Arithmetic: all unsigned. Intermediate partial remainder is BW+1 bits; q and r are exact with no truncation.

Optional Feature:
- Macro SEL_DIV_EARLY_EXIT_EN.
- Defined: in IDLE on accept, if divisor==0 or diff < divisor, skip CALC and go straight to DONE.
  - out_valid appears one cycle after accept.
  - divisor==0: q = all ones, r = diff.
  - diff < divisor: q = 0, r = diff.
- Undefined: every request takes the full BW-cycle CALC path.
- q/r/div_zero values are identical in both builds; only latency differs.

Decomposition:
- Package sel_div_pkg holds:
  - state enum typedef (IDLE/CALC/DONE);
  - counter width constant/function $clog2(BW);
  - a reference model function div_ref(diff, divisor), for bench use.
- Sub-module sel_div_step: combinational single restoring step. Inputs pr (BW+1), next dividend bit, divisor; outputs new pr and q bit.

Test Plan (BW=8):
- sel=1, res=50, e=8, b=6, d=99 -> q=7, r=0, div_zero=0; out_valid 8 cycles after accept (1 with SEL_DIV_EARLY_EXIT_EN? no: 42>=6, still 8).
- sel=0, res=3, e=10, d=7 -> diff wraps to 249, q=35, r=4.
- sel=1, b=0, res=20, e=5 -> q=255, r=15, div_zero=1; early-exit build gives out_valid 1 cycle after accept.
- out_ready held 0 for 5 cycles in DONE -> q/r/out_valid stable; in_valid pulses during CALC/DONE are ignored (in_ready=0).
- Assert rst at the 4th CALC cycle -> next cycle IDLE, out_valid=0, q=r=0; a following request (res=100, e=0, d=9) -> q=11, r=1.
- Back-to-back: 200 random requests against div_ref, with random in_valid/out_ready gaps -> all match; no request is lost or duplicated.

Source files
------------

// File: rtl/sel_div_pkg.sv
// Shared types and helpers for sel_mul_add_inverter.
// The reference model div_ref is for bench use.
package sel_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } div_res_t;

  function automatic int unsigned cnt_width(input int unsigned bw);
    return (bw < 2) ? 1 : $clog2(bw);
  endfunction

  // A zero divisor yields all-ones quotient and remainder = diff,
  // which matches what the restoring datapath produces.
  function automatic div_res_t div_ref(input logic [31:0] diff, input logic [31:0] divisor,
                                       input int unsigned bw);
    div_res_t res;
    if (divisor == 32'd0) begin
      res.q = (bw >= 32) ? 32'hffff_ffff : ((32'd1 << bw) - 32'd1);
      res.r = diff;
    end else begin
      res.q = diff / divisor;
      res.r = diff % divisor;
    end
    return res;
  endfunction

endpackage

// File: rtl/sel_div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor if it fits.
module sel_div_step #(
  parameter int unsigned BW = 8
) (
  input  logic [BW:0]   pr,
  input  logic          dbit,
  input  logic [BW-1:0] divisor,
  output logic [BW:0]   pr_next,
  output logic          qbit
);

  logic [BW:0] shifted;
  logic [BW:0] div_ext;

  assign shifted = {pr[BW-1:0], dbit};
  assign div_ext = {1'b0, divisor};

  always_comb begin
    pr_next = shifted;
    qbit    = 1'b0;
    if (shifted >= div_ext) begin
      pr_next = shifted - div_ext;
      qbit    = 1'b1;
    end
  end

endmodule

// File: rtl/sel_mul_add_inverter.sv
// Recovers the other factor of (sel ? a*b : c*d) + e with a bit-serial restoring divider.
// Optional macro SEL_DIV_EARLY_EXIT_EN skips the loop for zero divisor or diff < divisor.
module sel_mul_add_inverter
  import sel_div_pkg::*;
#(
  parameter int unsigned BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] res,
  input  logic [BW-1:0] e,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] d,
  input  logic          sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] q,
  output logic [BW-1:0] r,
  output logic          div_zero
);

  localparam int unsigned CntW = cnt_width(BW);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BW-1:0]   diff_q, diff_d;
  logic [BW-1:0]   divisor_q, divisor_d;
  logic [BW-1:0]   quo_q, quo_d;
  logic [BW-1:0]   q_q, q_d;
  logic [BW-1:0]   r_q, r_d;
  logic            dz_q, dz_d;
  logic [BW:0]     pr_q, pr_d;

  logic [BW-1:0]   diff_in;
  logic [BW-1:0]   divisor_in;
  logic [BW:0]     pr_step;
  logic            qbit;

  // Subtraction wraps modulo 2^BW by design.
  assign diff_in    = res - e;
  assign divisor_in = sel ? b : d;

  sel_div_step #(
    .BW(BW)
  ) u_step (
    .pr      (pr_q),
    .dbit    (diff_q[cnt_q]),
    .divisor (divisor_q),
    .pr_next (pr_step),
    .qbit    (qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    pr_d      = pr_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          diff_d    = diff_in;
          divisor_d = divisor_in;
          dz_d      = (divisor_in == '0);
          pr_d      = '0;
          quo_d     = '0;
          cnt_d     = CntW'(BW - 1);
          state_d   = StCalc;
`ifdef SEL_DIV_EARLY_EXIT_EN
          if ((divisor_in == '0) || (diff_in < divisor_in)) begin
            q_d     = (divisor_in == '0) ? '1 : '0;
            r_d     = diff_in;
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        pr_d  = pr_step;
        quo_d = {quo_q[BW-2:0], qbit};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          q_d     = {quo_q[BW-2:0], qbit};
          r_d     = pr_step[BW-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      diff_q    <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      pr_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
      pr_q      <= pr_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign q         = q_q;
  assign r         = r_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_sel_mul_add_inverter.sv
// Directed and randomised checks of sel_mul_add_inverter (BW=8), covering
// latency with and without SEL_DIV_EARLY_EXIT_EN.
module tb_sel_mul_add_inverter;
  import sel_div_pkg::*;

  localparam int unsigned BW = 8;
`ifdef SEL_DIV_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef struct packed {
    logic [BW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] res = '0;
  logic [BW-1:0] e = '0;
  logic [BW-1:0] b = '0;
  logic [BW-1:0] d = '0;
  logic          sel = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] q;
  logic [BW-1:0] r;
  logic          div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_out    = 0;

  sel_mul_add_inverter #(
    .BW(BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res       (res),
    .e         (e),
    .b         (b),
    .d         (d),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) n_acc <= n_acc + 1;
    if (!rst && out_valid && out_ready) n_out <= n_out + 1;
  end

  // Presents one request at a negedge and returns the number of rising edges
  // between the accept edge and the first negedge showing out_valid (-1 on timeout).
  task automatic drive_req(input logic [BW-1:0] res_v, input logic [BW-1:0] e_v,
                           input logic [BW-1:0] b_v, input logic [BW-1:0] d_v,
                           input logic sel_v, output int lat);
    @(negedge clk);
    res = res_v; e = e_v; b = b_v; d = d_v; sel = sel_v;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== '0 || r !== '0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%0d r=%0d dz=%b, want 1 0 0 0 0",
               in_ready, out_valid, q, r, div_zero);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mul_path();
    int lat;
    drive_req(8'd50, 8'd8, 8'd6, 8'd99, 1'b1, lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL mul_path_latency: got %0d want 8", lat);
    end
    n_checks++;
    if (q !== 8'd7 || r !== 8'd0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_path_result: q=%0d r=%0d dz=%b, want 7 0 0", q, r, div_zero);
    end
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 8'd7) begin
      n_fail++;
      $display("FAIL mul_path_release: out_valid=%b in_ready=%b q=%0d, want 0 1 7",
               out_valid, in_ready, q);
    end
  endtask

  task automatic test_wrap();
    int lat;
    drive_req(8'd3, 8'd10, 8'd77, 8'd7, 1'b0, lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL wrap_latency: got %0d want 8", lat);
    end
    n_checks++;
    if (q !== 8'd35 || r !== 8'd4 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_result: q=%0d r=%0d dz=%b, want 35 4 0", q, r, div_zero);
    end
    release_out();
  endtask

  task automatic test_div_zero();
    int lat;
    int want_lat;
    want_lat = EarlyExit ? 0 : 8;
    drive_req(8'd20, 8'd5, 8'd0, 8'd3, 1'b1, lat);
    n_checks++;
    if (lat !== want_lat) begin
      n_fail++;
      $display("FAIL div_zero_latency: got %0d want %0d", lat, want_lat);
    end
    n_checks++;
    if (q !== 8'd255 || r !== 8'd15 || div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero_result: q=%0d r=%0d dz=%b, want 255 15 1", q, r, div_zero);
    end
    release_out();
  endtask

  // Junk requests are held on in_valid through CALC and DONE; they must be ignored.
  task automatic test_stall();
    int lat;
    bit ready_seen;
    @(negedge clk);
    res = 8'd200; e = 8'd0; d = 8'd13; b = 8'd1; sel = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    res = 8'd0; e = 8'd0; b = 8'd1; d = 8'd1; sel = 1'b1;
    lat = -1;
    ready_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (lat !== 8 || ready_seen) begin
      n_fail++;
      $display("FAIL stall_calc: latency %0d in_ready_seen=%b, want 8 0", lat, ready_seen);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== 8'd15 || r !== 8'd5 ||
          div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: ov=%b ir=%b q=%0d r=%0d dz=%b, want 1 0 15 5 0",
                 i, out_valid, in_ready, q, r, div_zero);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    release_out();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 8'd15 || r !== 8'd5) begin
      n_fail++;
      $display("FAIL stall_after: ov=%b ir=%b q=%0d r=%0d, want 0 1 15 5",
               out_valid, in_ready, q, r);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    @(negedge clk);
    res = 8'd250; e = 8'd0; b = 8'd3; d = 8'd0; sel = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== '0 || r !== '0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: ov=%b ir=%b q=%0d r=%0d dz=%b, want 0 1 0 0 0",
               out_valid, in_ready, q, r, div_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_pulse: out_valid=%b want 0", out_valid);
      end
    end
    drive_req(8'd100, 8'd0, 8'd55, 8'd9, 1'b0, lat);
    n_checks++;
    if (lat !== 8 || q !== 8'd11 || r !== 8'd1 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_req: lat=%0d q=%0d r=%0d dz=%b, want 8 11 1 0",
               lat, q, r, div_zero);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    exp_t exp_q[$];
    int   acc0;
    int   out0;
    int   got;
    int   sent;
    acc0 = n_acc;
    out0 = n_out;
    got  = 0;
    sent = 0;
    fork
      begin : driver
        for (int i = 0; i < 200; i++) begin
          logic [BW-1:0] divisor;
          logic [BW-1:0] diff;
          div_res_t      ref_v;
          exp_t          ex;
          bit            acc;
          int            wd;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          res = BW'($urandom);
          e   = BW'($urandom);
          b   = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom_range(1, 40));
          d   = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
          sel = 1'($urandom);
          divisor = sel ? b : d;
          diff    = res - e;
          ref_v   = div_ref(32'(diff), 32'(divisor), BW);
          ex.q  = ref_v.q[BW-1:0];
          ex.r  = ref_v.r[BW-1:0];
          ex.dz = (divisor == '0);
          exp_q.push_back(ex);
          in_valid = 1'b1;
          acc = 1'b0;
          wd  = 0;
          while (!acc && wd < 200) begin
            acc = in_ready;
            @(negedge clk);
            wd++;
          end
          in_valid = 1'b0;
          if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_accept_timeout: request %0d not accepted", i);
            break;
          end
          sent++;
        end
      end
      begin : consumer
        int wd;
        exp_t ex;
        wd = 0;
        while (got < 200 && wd < 20000) begin
          out_ready = 1'($urandom);
          if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL b2b_extra: result q=%0d r=%0d with nothing pending", q, r);
            end else begin
              ex = exp_q.pop_front();
              if (q !== ex.q || r !== ex.r || div_zero !== ex.dz) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: q=%0d r=%0d dz=%b, want %0d %0d %b",
                         got, q, r, div_zero, ex.q, ex.r, ex.dz);
              end
            end
            got++;
          end
          @(negedge clk);
          wd++;
        end
        out_ready = 1'b0;
      end
    join
    n_checks++;
    if (got !== 200 || sent !== 200 || exp_q.size() !== 0 || (n_acc - acc0) !== 200 ||
        (n_out - out0) !== 200) begin
      n_fail++;
      $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d acc=%0d out=%0d, want 200 200 0 200 200",
               sent, got, exp_q.size(), n_acc - acc0, n_out - out0);
    end
  endtask

  initial begin
    test_reset();
    test_mul_path();
    test_wrap();
    test_div_zero();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
